// File: rtl/bp_pkg.sv
// Branch predictor shared types: 2-bit saturating direction counter
// encoding and its next-state function.
package bp_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t SNT = 2'b00;
  localparam ctr_t WNT = 2'b01;
  localparam ctr_t WT  = 2'b10;
  localparam ctr_t ST  = 2'b11;

  // Saturating step toward taken (+1) or not-taken (-1).
  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    ctr_t n;
    if (taken) n = (c == ST)  ? ST  : ctr_t'(c + 2'd1);
    else       n = (c == SNT) ? SNT : ctr_t'(c - 2'd1);
    return n;
  endfunction

endpackage

// File: rtl/bp_table.sv
// Direct-mapped BTB + BHT: valid/tag/target/counter arrays.
// Combinational read port for fetch lookup, synchronous write port for
// execute-stage resolution. Reads see pre-write state within a cycle.
module bp_table
  import bp_pkg::*;
#(
  parameter int PC_WIDTH = 10,
  parameter int ENTRIES  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_WIDTH-1:0] rd_pc,
  output logic                rd_taken,
  output logic [PC_WIDTH-1:0] rd_tgt,
  input  logic                wr_en,
  input  logic [PC_WIDTH-1:0] wr_pc,
  input  logic                wr_taken,
  input  logic [PC_WIDTH-1:0] wr_target
);

  localparam int IDX_BITS = $clog2(ENTRIES);
  localparam int TAG_BITS = PC_WIDTH - IDX_BITS;

  logic [ENTRIES-1:0]               valid_q;
  logic [ENTRIES-1:0][TAG_BITS-1:0] tag_q;
  logic [ENTRIES-1:0][PC_WIDTH-1:0] tgt_q;
  ctr_t [ENTRIES-1:0]               ctr_q;

  logic [IDX_BITS-1:0] rd_idx, wr_idx;
  logic [TAG_BITS-1:0] rd_tag, wr_tag;
  logic                rd_hit, wr_hit;

  assign rd_idx = rd_pc[IDX_BITS-1:0];
  assign rd_tag = rd_pc[PC_WIDTH-1:IDX_BITS];
  assign wr_idx = wr_pc[IDX_BITS-1:0];
  assign wr_tag = wr_pc[PC_WIDTH-1:IDX_BITS];

  // Lookup: predict taken only on a tag hit with the counter's MSB set.
  always_comb begin
    rd_hit   = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    rd_taken = rd_hit && ctr_q[rd_idx][1];
    rd_tgt   = tgt_q[rd_idx];
    wr_hit   = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
  end

  // Resolution update: train on hit, allocate weakly-taken on taken miss
  // (evicting any alias), ignore not-taken misses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      tag_q   <= '0;
      tgt_q   <= '0;
      ctr_q   <= {ENTRIES{WNT}};
    end else if (wr_en) begin
      if (wr_hit) begin
        ctr_q[wr_idx] <= ctr_next(ctr_q[wr_idx], wr_taken);
        if (wr_taken) tgt_q[wr_idx] <= wr_target;
      end else if (wr_taken) begin
        valid_q[wr_idx] <= 1'b1;
        tag_q[wr_idx]   <= wr_tag;
        tgt_q[wr_idx]   <= wr_target;
        ctr_q[wr_idx]   <= WT;
      end
    end
  end

endmodule

// File: rtl/branch_predict_pc.sv
// Fetch PC unit with dynamic branch prediction. Owns the PC register and
// next-PC mux (mispredict redirect > stall > prediction) and drives the
// BTB/BHT. Optional resolution statistics under `BP_STATS_EN.
module branch_predict_pc
  import bp_pkg::*;
#(
  parameter int                  PC_WIDTH = 10,
  parameter int                  ENTRIES  = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  output logic [PC_WIDTH-1:0] pc,
  output logic                pred_taken,
  output logic [PC_WIDTH-1:0] pred_target,
  input  logic                upd_valid,
  input  logic [PC_WIDTH-1:0] upd_pc,
  input  logic                upd_taken,
  input  logic [PC_WIDTH-1:0] upd_target,
  input  logic                upd_mispredict,
  output logic [31:0]         branch_count,
  output logic [31:0]         mispredict_count
);

  logic [PC_WIDTH-1:0] tbl_tgt, pc_next;
  logic                redirect;

  bp_table #(.PC_WIDTH(PC_WIDTH), .ENTRIES(ENTRIES)) u_table (
    .clk       (clk),
    .rst       (rst),
    .rd_pc     (pc),
    .rd_taken  (pred_taken),
    .rd_tgt    (tbl_tgt),
    .wr_en     (upd_valid),
    .wr_pc     (upd_pc),
    .wr_taken  (upd_taken),
    .wr_target (upd_target)
  );

  assign redirect = upd_valid && upd_mispredict;

  // Prediction and next-PC select; all arithmetic wraps at PC_WIDTH.
  always_comb begin
    pred_target = pred_taken ? tbl_tgt : pc + PC_WIDTH'(1);
    if (redirect)   pc_next = upd_taken ? upd_target : upd_pc + PC_WIDTH'(1);
    else if (stall) pc_next = pc;
    else            pc_next = pred_target;
  end

  // PC register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= RESET_PC;
    else     pc <= pc_next;
  end

`ifdef BP_STATS_EN
  logic [31:0] br_q, mp_q;

  // Saturating resolution and mispredict counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_q <= '0;
      mp_q <= '0;
    end else if (upd_valid) begin
      if (br_q != '1) br_q <= br_q + 32'd1;
      if (upd_mispredict && (mp_q != '1)) mp_q <= mp_q + 32'd1;
    end
  end

  assign branch_count     = br_q;
  assign mispredict_count = mp_q;
`else
  assign branch_count     = '0;
  assign mispredict_count = '0;
`endif

endmodule

// File: doc/branch_predict_pc.md
# branch_predict_pc

Parametrised program-counter unit with dynamic branch prediction for the pipelined core. It owns the PC register and selects the next fetch address from a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. It also applies execute-stage resolution updates and mispredict redirects. It replaces the static PC+1/branch/jump/JR next-PC mux of the single-cycle datapath at the fetch stage.

## Interface
Parameters:
- PC_WIDTH, 10, word-address width of PC and targets
- ENTRIES, 16, BTB/BHT depth; power of two, ≥2; IDX_BITS = log2(ENTRIES)
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hold PC (fetch stall)
- pc  out  PC_WIDTH  current fetch address (registered)
- pred_taken  out  1  prediction for `pc` (combinational)
- pred_target  out  PC_WIDTH  predicted target for `pc`; equals pc+1 when not taken
- upd_valid  in  1  a control-transfer instruction resolved this cycle
- upd_pc  in  PC_WIDTH  address of the resolved instruction
- upd_taken  in  1  actual direction; jumps/JR/JAL report 1
- upd_target  in  PC_WIDTH  actual taken target
- upd_mispredict  in  1  pipeline-carried prediction differed in direction or target; qualified by upd_valid
- branch_count  out  32  resolved control transfers (BP_STATS_EN only)
- mispredict_count  out  32  mispredicts (BP_STATS_EN only)

## Operation
- Lookup: idx = pc[IDX_BITS-1:0], tag = pc[PC_WIDTH-1:IDX_BITS]. Hit = valid[idx] & tag match. pred_taken = hit & ctr[idx][1]. pred_target = pred_taken ? tgt[idx] : pc+1.
- Next PC priority: (1) upd_valid & upd_mispredict → upd_taken ? upd_target : upd_pc+1, overriding stall; (2) stall → hold; (3) pred_target.
- Update (upd_valid), entry at upd_pc's index:
  - Hit: ctr saturating +1 if taken, −1 if not taken. Target overwritten with upd_target when taken.
  - Miss and taken: allocate (valid=1, tag, target, ctr=WT), replacing any aliasing entry.
  - Miss and not taken: no change.
- Counter states: SNT=00, WNT=01, WT=10, ST=11. Saturates at 00 and 11.
- All PC arithmetic is modulo 2^PC_WIDTH; 0x3FF+1 = 0x000 at PC_WIDTH=10.

## Timing
- Reset values (asynchronous, immediate, also mid-operation): pc=RESET_PC; all valid=0; all ctr=WNT; tgt=0; counters=0; pred_taken=0; pred_target=RESET_PC+1.
- Lookup latency 0 cycles; pc changes only on clk edge.
- Redirect: upd_mispredict at edge n → pc=target after edge n.
- Table writes take effect at the edge. A lookup and an update to the same index in one cycle: the lookup sees the pre-update state. The update is visible from the next cycle.
- Update and redirect happen together when both are signalled; stall does not block updates.

## Configuration
- BP_STATS_EN defined: branch_count increments on each upd_valid and mispredict_count on each upd_valid & upd_mispredict. Both are 32-bit, saturate at 0xFFFFFFFF, and are cleared by rst.
- BP_STATS_EN undefined: no counter flops; both outputs are tied to 0.

## Structure
- Package bp_pkg: counter state constants SNT/WNT/WT/ST, a 2-bit counter type, and a saturating next-state function ctr_next(ctr, taken).
- Sub-module bp_table: valid/tag/target/ctr arrays. It has a combinational read port (lookup) and a synchronous write port (update), with async reset. The top level holds the PC register, next-PC mux and stats.

## Test plan
- Reset/sequential: rst=1 → pc=0x000, pred_taken=0. Release with no updates → pc 0x000, 0x001, 0x002, 0x003 on consecutive edges. Drive rst mid-run → pc=0x000 immediately.
- Cold branch: upd_pc=0x005, taken, upd_target=0x040, mispredict → pc=0x040 next edge. On the next visit to pc=0x005: pred_taken=1, pred_target=0x040, following pc=0x040.
- Hysteresis: entry 5 at WT, resolve not-taken with mispredict → redirect to 0x006, ctr=WNT. Next visit at 0x005 → pred_taken=0, pred_target=0x006. Three taken updates → ctr=ST and holds at 11.
- Alias: entry 5 allocated for 0x005; lookup at 0x015 (same idx, different tag) → pred_taken=0. Taken update at 0x015 → entry replaced, and 0x005 then misses.
- Stall vs redirect: stall=1 alone → pc held for 3 cycles. stall=1 with mispredict to 0x100 → pc=0x100. Same-cycle update and lookup at index 5 → pred_taken reflects the old ctr.
- Wrap/stats (BP_STATS_EN): pc=0x3FF, no hit → next pc=0x000. After 4 updates, 2 of them mispredicted → branch_count=4, mispredict_count=2. Without the macro both read 0.
